// File: rtl/cv32e40p_sleep_ctrl.sv
// Multi-domain sleep / clock-gating controller: idle-gates auxiliary domains in RUN and sequences WFI sleep.
// Optional sleep-cycle statistics counter is built when CV32E40P_SLEEP_STATS_EN is defined.

module cv32e40p_clock_gate (
    input  logic clk_i,
    input  logic en_i,
    input  logic test_en_i,
    output logic clk_o
);

    logic clk_en;

    // Transparent while the clock is low so enable changes never glitch the output.
    always_latch begin
        if (clk_i == 1'b0) begin
            clk_en <= en_i | test_en_i;
        end
    end

    assign clk_o = clk_i & clk_en;

endmodule

module cv32e40p_sleep_ctrl #(
    parameter int NUM_DOMAINS = 3,
    parameter int NUM_WAKE    = 4,
    parameter int SLEEP_DELAY = 2,
    parameter int WAKE_CYCLES = 1,
    parameter int CNT_W       = 32
) (
    input  logic                   clk_ungated_i,
    input  logic                   rst_i,
    input  logic                   scan_cg_en_i,
    output logic [NUM_DOMAINS-1:0] clk_gated_o,
    input  logic                   fetch_enable_i,
    output logic                   fetch_enable_o,
    input  logic [NUM_DOMAINS-1:0] busy_i,
    input  logic [NUM_DOMAINS-1:0] dom_idle_en_i,
    input  logic                   sleep_req_i,
    input  logic                   debug_no_sleep_i,
    input  logic [NUM_WAKE-1:0]    wake_i,
    input  logic [NUM_WAKE-1:0]    wake_mask_i,
    output logic                   core_sleep_o,
    output logic                   wake_ack_o,
    output logic [CNT_W-1:0]       sleep_cnt_o
);

    localparam int IDLE_W = (SLEEP_DELAY > 1) ? $clog2(SLEEP_DELAY) : 1;
    localparam int WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

    typedef enum logic [2:0] {
        RESET,
        RUN,
        DRAIN,
        SLEEP,
        WAKE
    } state_e;

    state_e                 state_reg, state_next;
    logic                   fetch_en_reg;
    logic [NUM_DOMAINS-1:0] busy_reg;
    logic [IDLE_W-1:0]      idle_cnt_reg, idle_cnt_next;
    logic [WAKE_W-1:0]      wake_cnt_reg, wake_cnt_next;
    logic [NUM_DOMAINS-1:0] run_en;
    logic [NUM_DOMAINS-1:0] dom_en;
    logic [NUM_DOMAINS-1:0] gate_en;
    logic                   ack_raw;
    logic                   wake_any;
    logic                   all_idle;
    logic                   unused_bits;

    assign wake_any = |(wake_i & wake_mask_i);
    assign all_idle = ~|busy_i;

    // The core domain never idle-gates in RUN, so its busy/idle-enable bits are not consulted.
    assign unused_bits = dom_idle_en_i[0] ^ busy_reg[0];
    assign run_en[0]   = 1'b1;

    generate
        for (genvar gi = 1; gi < NUM_DOMAINS; gi++) begin : g_run_en
            assign run_en[gi] = busy_i[gi] | busy_reg[gi] | ~dom_idle_en_i[gi];
        end
    endgenerate

    always_ff @(posedge clk_ungated_i) begin
        if (rst_i) begin
            state_reg    <= RESET;
            fetch_en_reg <= 1'b0;
            busy_reg     <= '0;
            idle_cnt_reg <= '0;
            wake_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            fetch_en_reg <= fetch_en_reg | fetch_enable_i;
            busy_reg     <= busy_i;
            idle_cnt_reg <= idle_cnt_next;
            wake_cnt_reg <= wake_cnt_next;
        end
    end

    // Counters default to zero so they are clear on every state entry.
    always_comb begin
        state_next    = state_reg;
        dom_en        = '0;
        idle_cnt_next = '0;
        wake_cnt_next = '0;
        ack_raw       = 1'b0;
        case (state_reg)
            RESET: begin
                if (fetch_en_reg) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                dom_en = run_en;
                if (sleep_req_i && !debug_no_sleep_i) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                dom_en = '1;
                if (debug_no_sleep_i || !sleep_req_i) begin
                    state_next = RUN;
                end else if (wake_any) begin
                    state_next = RUN;
                    ack_raw    = 1'b1;
                end else if (all_idle && idle_cnt_reg == IDLE_W'(SLEEP_DELAY - 1)) begin
                    state_next = SLEEP;
                end else if (all_idle) begin
                    idle_cnt_next = idle_cnt_reg + IDLE_W'(1);
                end
            end
            SLEEP: begin
                // Combinational so a single-cycle wake pulse clocks the edge that leaves SLEEP.
                dom_en = {NUM_DOMAINS{wake_any | debug_no_sleep_i}};
                if (wake_any || debug_no_sleep_i) begin
                    state_next = WAKE;
                end
            end
            WAKE: begin
                dom_en = '1;
                if (wake_cnt_reg == WAKE_W'(WAKE_CYCLES - 1)) begin
                    ack_raw    = 1'b1;
                    state_next = RUN;
                end else begin
                    wake_cnt_next = wake_cnt_reg + WAKE_W'(1);
                end
            end
            default: begin
                state_next = RESET;
            end
        endcase
    end

    assign gate_en        = dom_en & {NUM_DOMAINS{fetch_en_reg}};
    assign fetch_enable_o = fetch_en_reg;
    assign core_sleep_o   = (state_reg == SLEEP);
    // A reset arriving mid-wake aborts the sequence, so no acknowledge escapes.
    assign wake_ack_o     = ack_raw & ~rst_i;

    generate
        for (genvar gi = 0; gi < NUM_DOMAINS; gi++) begin : g_gate
            cv32e40p_clock_gate u_gate (
                .clk_i     (clk_ungated_i),
                .en_i      (gate_en[gi]),
                .test_en_i (scan_cg_en_i),
                .clk_o     (clk_gated_o[gi])
            );
        end
    endgenerate

`ifdef CV32E40P_SLEEP_STATS_EN
    logic [CNT_W-1:0] sleep_cnt_reg;

    always_ff @(posedge clk_ungated_i) begin
        if (rst_i) begin
            sleep_cnt_reg <= '0;
        end else if (state_reg == SLEEP && sleep_cnt_reg != {CNT_W{1'b1}}) begin
            sleep_cnt_reg <= sleep_cnt_reg + CNT_W'(1);
        end
    end

    assign sleep_cnt_o = sleep_cnt_reg;
`else
    assign sleep_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_sleep_ctrl.sv
// Randomized bench for cv32e40p_sleep_ctrl against a cycle model built from the phase rules.
// Honours CV32E40P_SLEEP_STATS_EN for the expected statistics counter.

module tb_cv32e40p_sleep_ctrl;

    localparam int ND  = 3;
    localparam int NW  = 4;
    localparam int SD  = 2;
    localparam int WC  = 1;
    localparam int CW  = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    localparam int M_RESET = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_SLEEP = 3;
    localparam int M_WAKE  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          scan;
    logic [ND-1:0] clk_gated;
    logic          fetch_i;
    logic          fetch_o;
    logic [ND-1:0] busy;
    logic [ND-1:0] idle_en;
    logic          req;
    logic          dbg;
    logic [NW-1:0] wake;
    logic [NW-1:0] mask;
    logic          core_sleep;
    logic          ack;
    logic [CW-1:0] sleep_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int n_acks   = 0;
    int n_sleep_cycles_seen = 0;

    // Reference model: phase, fetch latch, previous busy, and plain counters.
    int            m_mode;
    bit            m_fetch;
    bit [ND-1:0]   m_busy_prev;
    int            m_idle_run;
    int            m_wake_cycles;
    int            m_sleep_cycles;

    always #5 clk = ~clk;

    cv32e40p_sleep_ctrl #(
        .NUM_DOMAINS (ND),
        .NUM_WAKE    (NW),
        .SLEEP_DELAY (SD),
        .WAKE_CYCLES (WC),
        .CNT_W       (CW)
    ) dut (
        .clk_ungated_i    (clk),
        .rst_i            (rst),
        .scan_cg_en_i     (scan),
        .clk_gated_o      (clk_gated),
        .fetch_enable_i   (fetch_i),
        .fetch_enable_o   (fetch_o),
        .busy_i           (busy),
        .dom_idle_en_i    (idle_en),
        .sleep_req_i      (req),
        .debug_no_sleep_i (dbg),
        .wake_i           (wake),
        .wake_mask_i      (mask),
        .core_sleep_o     (core_sleep),
        .wake_ack_o       (ack),
        .sleep_cnt_o      (sleep_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode         = M_RESET;
        m_fetch        = 1'b0;
        m_busy_prev    = '0;
        m_idle_run     = 0;
        m_wake_cycles  = 0;
        m_sleep_cycles = 0;
    endtask

    function automatic bit wake_seen();
        return |(wake & mask);
    endfunction

    function automatic logic [ND-1:0] model_enables();
        logic [ND-1:0] e;
        for (int d = 0; d < ND; d++) begin
            case (m_mode)
                M_RUN:   e[d] = (d == 0) || busy[d] || m_busy_prev[d] || !idle_en[d];
                M_DRAIN: e[d] = 1'b1;
                M_WAKE:  e[d] = 1'b1;
                M_SLEEP: e[d] = wake_seen() || dbg;
                default: e[d] = 1'b0;
            endcase
            e[d] = (e[d] && m_fetch) || scan;
        end
        return e;
    endfunction

    function automatic bit model_ack();
        if (rst) return 1'b0;
        if (m_mode == M_DRAIN) return req && !dbg && wake_seen();
        if (m_mode == M_WAKE)  return (m_wake_cycles + 1) == WC;
        return 1'b0;
    endfunction

    function automatic int model_cnt();
`ifdef CV32E40P_SLEEP_STATS_EN
        return (m_sleep_cycles > CNT_MAX) ? CNT_MAX : m_sleep_cycles;
`else
        return 0;
`endif
    endfunction

    task automatic model_step();
        if (rst) begin
            model_reset();
            return;
        end
        if (m_mode == M_SLEEP) m_sleep_cycles++;
        case (m_mode)
            M_RESET: if (m_fetch) m_mode = M_RUN;
            M_RUN: begin
                if (req && !dbg) begin
                    m_mode     = M_DRAIN;
                    m_idle_run = 0;
                end
            end
            M_DRAIN: begin
                if (dbg || !req || wake_seen()) begin
                    m_mode = M_RUN;
                end else if (busy == '0) begin
                    m_idle_run++;
                    if (m_idle_run == SD) m_mode = M_SLEEP;
                end else begin
                    m_idle_run = 0;
                end
            end
            M_SLEEP: begin
                if (wake_seen() || dbg) begin
                    m_mode        = M_WAKE;
                    m_wake_cycles = 0;
                end
            end
            M_WAKE: begin
                m_wake_cycles++;
                if (m_wake_cycles == WC) m_mode = M_RUN;
            end
            default: m_mode = M_RESET;
        endcase
        m_fetch     = m_fetch | fetch_i;
        m_busy_prev = busy;
    endtask

    // Entered at posedge+1 with inputs already driven; leaves at the next posedge+1.
    task automatic tick();
        logic [ND-1:0] exp_en;
        bit            exp_ack;
        #1;
        exp_en  = model_enables();
        exp_ack = model_ack();
        check_val("wake_ack", ack, exp_ack);
        if (ack) begin
            n_acks++;
            $display("ack: t=%0t mode=%0d wake=%b mask=%b dbg=%b", $time, m_mode, wake, mask, dbg);
        end
        model_step();
        @(posedge clk);
        #1;
        check_val("clk_gated", clk_gated, exp_en);
        check_val("core_sleep", core_sleep, m_mode == M_SLEEP);
        check_val("fetch_en", fetch_o, m_fetch);
        check_val("sleep_cnt", sleep_cnt, model_cnt());
        if (core_sleep) n_sleep_cycles_seen++;
    endtask

    task automatic rand_inputs(input int p_req, input int p_busy, input int p_wake, input int p_dbg);
        rst     = ($urandom_range(0, 399) == 0);
        scan    = ($urandom_range(0, 99) == 0);
        fetch_i = ($urandom_range(0, 29) == 0);
        req     = ($urandom_range(0, 99) < p_req);
        for (int d = 0; d < ND; d++) busy[d] = ($urandom_range(0, 99) < p_busy);
        for (int w = 0; w < NW; w++) wake[w] = ($urandom_range(0, 99) < p_wake);
        idle_en = ND'($urandom);
        mask    = NW'($urandom);
        dbg     = ($urandom_range(0, 99) < p_dbg);
    endtask

    // Random profiles: {p_req, p_busy, p_wake, p_dbg}
    int prof [4][4] = '{'{90, 5, 3, 2}, '{60, 30, 10, 5}, '{95, 2, 1, 10}, '{40, 50, 20, 20}};

    initial begin
        rst = 1'b1; scan = 1'b0; fetch_i = 1'b0; busy = '0; idle_en = '0;
        req = 1'b0; dbg = 1'b0; wake = '0; mask = '0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;

        // Fetch enable held low, then a single pulse.
        repeat (10) tick();
        fetch_i = 1'b1; tick();
        fetch_i = 1'b0; repeat (2) tick();

        // Idle gating of auxiliary domains after busy falls.
        idle_en = 3'b110; busy = 3'b010;
        repeat (3) tick();
        busy = 3'b000;
        repeat (3) tick();

        // Sleep, then a single-cycle masked-in wake pulse.
        mask = 4'b0100; req = 1'b1;
        repeat (5) tick();
        wake = 4'b0100; req = 1'b0; tick();
        wake = 4'b0000; repeat (3) tick();

        // Masked-off wake in DRAIN is ignored; debug exits SLEEP.
        mask = 4'b0000; wake = 4'b0001; req = 1'b1;
        repeat (5) tick();
        req = 1'b0; dbg = 1'b1; tick();
        dbg = 1'b0; repeat (2) tick();

        // Unmasked wake in DRAIN aborts sleep with an acknowledge.
        mask = 4'b0001; req = 1'b1;
        repeat (3) tick();
        req = 1'b0; wake = 4'b0000; repeat (2) tick();

        // Long sleep for counter saturation, then reset in SLEEP.
        req = 1'b1;
        repeat (24) tick();
        rst = 1'b1; tick();
        rst = 1'b0; req = 1'b0; repeat (2) tick();

        for (int b = 0; b < 20; b++) begin
            int p;
            p = $urandom_range(0, 3);
            for (int c = 0; c < 200; c++) begin
                rand_inputs(prof[p][0], prof[p][1], prof[p][2], prof[p][3]);
                tick();
            end
        end

        check_val("dut_slept", (n_sleep_cycles_seen != 0), 1);
        check_val("dut_acked", (n_acks != 0), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
